fram_i2c_ctrl: RTL and testbench



---
 rtl/fram_i2c_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_fram_i2c_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fram_i2c_ctrl.sv
// -----------------------------------------------------------------------------
// fram_i2c_ctrl
//
// Turns simple read/write burst requests into the command/data protocol of a
// byte-oriented I2C master (start/read/write_multiple/stop commands plus an
// outbound byte stream and an inbound byte stream) to access an I2C FRAM.
//
// Write transaction: start + write_multiple command, word address bytes
// (MSB first), payload bytes, then a stop command.
// Read transaction: start + write_multiple command, word address bytes (last
// one flagged tlast), then one read command per byte (start on the first,
// stop on the last), each followed by forwarding the returned byte.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write/addr/len       request direction, FRAM word address, byte count
//   wr_t*                    write payload stream (passed through to m_t*)
//   rd_t*                    read payload stream (passed through from s_t*)
//   done, err                completion pulse and status of last transaction
//   cmd_*                    command channel towards the I2C master
//   m_t*                     bytes towards the bus
//   s_t*                     bytes from the bus
//   i2c_busy, i2c_missed_ack master status inputs
// -----------------------------------------------------------------------------
module fram_i2c_ctrl #(
    parameter int         ADDR_BYTES = 1,
    parameter logic [2:0] DEV_SEL    = 3'b000,
    parameter int         MAX_BURST  = 16,
    parameter int         TIMEOUT    = 100000,
    localparam int        LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [LEN_W-1:0]        req_len,

    input  logic [7:0]              wr_tdata,
    input  logic                    wr_tvalid,
    output logic                    wr_tready,

    output logic [7:0]              rd_tdata,
    output logic                    rd_tvalid,
    input  logic                    rd_tready,
    output logic                    rd_tlast,

    output logic                    done,
    output logic                    err,

    output logic [6:0]              cmd_address,
    output logic                    cmd_start,
    output logic                    cmd_read,
    output logic                    cmd_write_multiple,
    output logic                    cmd_stop,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,

    output logic [7:0]              m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,

    input  logic [7:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,

    input  logic                    i2c_busy,
    input  logic                    i2c_missed_ack
);

    localparam int         AW       = 8 * ADDR_BYTES;
    localparam int         AB_W     = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int         WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [6:0] I2C_ADDR = {4'b1010, DEV_SEL};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_W,
        S_ADDR,
        S_WDATA,
        S_CMD_R,
        S_RDATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic              write_reg, write_next;
    logic [AW-1:0]     addr_sh_reg, addr_sh_next;   // address, shifted left per sent byte
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;           // current payload byte, 1-based
    logic [AB_W-1:0]   abyte_reg, abyte_next;       // current address byte index
    logic [WD_W-1:0]   wdog_reg, wdog_next;
    logic              err_reg, err_next;

    logic              last_byte;
    logic              last_abyte;
    logic              active;
    logic              ack_fail;
    logic              tmo;
    logic              abort;
    logic [LEN_W-1:0]  len_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            write_reg   <= 1'b0;
            addr_sh_reg <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            abyte_reg   <= '0;
            wdog_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            write_reg   <= write_next;
            addr_sh_reg <= addr_sh_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            abyte_reg   <= abyte_next;
            wdog_reg    <= wdog_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        last_byte  = (cnt_reg == len_reg);
        last_abyte = (abyte_reg == AB_W'(ADDR_BYTES - 1));
        active     = (state_reg != S_IDLE) && (state_reg != S_DONE);
        // A missed ACK seen while already stopping only marks the error; the
        // stop command is still needed to release the bus.
        ack_fail   = active && i2c_missed_ack && (state_reg != S_STOP);
        tmo        = active && (wdog_reg == WD_W'(TIMEOUT - 1));
        abort      = ack_fail || tmo;

        if (req_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (req_len > LEN_W'(MAX_BURST)) begin
            len_clamped = LEN_W'(MAX_BURST);
        end else begin
            len_clamped = req_len;
        end
    end

    always_comb begin
        state_next         = state_reg;
        write_next         = write_reg;
        addr_sh_next       = addr_sh_reg;
        len_next           = len_reg;
        cnt_next           = cnt_reg;
        abyte_next         = abyte_reg;
        err_next           = err_reg;

        req_ready          = 1'b0;
        wr_tready          = 1'b0;
        rd_tdata           = 8'h00;
        rd_tvalid          = 1'b0;
        rd_tlast           = 1'b0;
        done               = 1'b0;
        cmd_start          = 1'b0;
        cmd_read           = 1'b0;
        cmd_write_multiple = 1'b0;
        cmd_stop           = 1'b0;
        cmd_valid          = 1'b0;
        m_tdata            = 8'h00;
        m_tvalid           = 1'b0;
        m_tlast            = 1'b0;
        s_tready           = 1'b0;

        // Outputs are forced low for as long as reset is held, not just
        // from the next clock edge.
        if (!rst) begin
            unique case (state_reg)
                S_IDLE: begin
                    req_ready = !i2c_busy;
                    if (req_valid && !i2c_busy) begin
                        write_next   = req_write;
                        addr_sh_next = req_addr;
                        len_next     = len_clamped;
                        cnt_next     = LEN_W'(1);
                        abyte_next   = '0;
                        err_next     = 1'b0;
                        state_next   = S_CMD_W;
                    end
                end

                S_CMD_W: begin
                    cmd_valid          = 1'b1;
                    cmd_start          = 1'b1;
                    cmd_write_multiple = 1'b1;
                    if (cmd_ready) begin
                        state_next = S_ADDR;
                    end
                end

                S_ADDR: begin
                    m_tvalid = 1'b1;
                    m_tdata  = addr_sh_reg[AW-1 -: 8];
                    // For reads the address write ends here, ahead of the
                    // repeated start.
                    m_tlast  = last_abyte && !write_reg;
                    if (m_tready) begin
                        if (last_abyte) begin
                            state_next = write_reg ? S_WDATA : S_CMD_R;
                        end else begin
                            abyte_next   = abyte_reg + AB_W'(1);
                            addr_sh_next = addr_sh_reg << 8;
                        end
                    end
                end

                S_WDATA: begin
                    m_tdata   = wr_tdata;
                    m_tvalid  = wr_tvalid;
                    m_tlast   = last_byte;
                    wr_tready = m_tready;
                    if (wr_tvalid && m_tready) begin
                        if (last_byte) begin
                            state_next = S_STOP;
                        end else begin
                            cnt_next = cnt_reg + LEN_W'(1);
                        end
                    end
                end

                S_CMD_R: begin
                    cmd_valid = 1'b1;
                    cmd_read  = 1'b1;
                    cmd_start = (cnt_reg == LEN_W'(1));
                    cmd_stop  = last_byte;
                    if (cmd_ready) begin
                        state_next = S_RDATA;
                    end
                end

                S_RDATA: begin
                    s_tready  = rd_tready;
                    rd_tvalid = s_tvalid;
                    rd_tdata  = s_tdata;
                    rd_tlast  = last_byte;
                    if (s_tvalid && rd_tready) begin
                        if (last_byte) begin
                            state_next = S_DONE;
                        end else begin
                            cnt_next   = cnt_reg + LEN_W'(1);
                            state_next = S_CMD_R;
                        end
                    end
                end

                S_STOP: begin
                    cmd_valid = 1'b1;
                    cmd_stop  = 1'b1;
                    if (cmd_ready) begin
                        state_next = S_DONE;
                    end
                end

                S_DONE: begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase

            if (active && (i2c_missed_ack || tmo)) begin
                err_next = 1'b1;
            end

            // On abort nothing is handshaken this cycle, so no byte or
            // command slips through while the state machine bails out.
            if (abort) begin
                wr_tready          = 1'b0;
                rd_tdata           = 8'h00;
                rd_tvalid          = 1'b0;
                rd_tlast           = 1'b0;
                cmd_start          = 1'b0;
                cmd_read           = 1'b0;
                cmd_write_multiple = 1'b0;
                cmd_stop           = 1'b0;
                cmd_valid          = 1'b0;
                m_tdata            = 8'h00;
                m_tvalid           = 1'b0;
                m_tlast            = 1'b0;
                s_tready           = 1'b0;
                cnt_next           = cnt_reg;
                abyte_next         = abyte_reg;
                addr_sh_next       = addr_sh_reg;
                if (ack_fail) begin
                    // A read command that already carried stop has closed
                    // the bus transaction itself.
                    state_next = (state_reg == S_RDATA && last_byte) ? S_DONE : S_STOP;
                end else begin
                    state_next = S_DONE;
                end
            end
        end

        cmd_address = cmd_valid ? I2C_ADDR : 7'h00;
        err         = err_reg;
    end

    // Watchdog measures time spent in the current state only.
    always_comb begin
        if (!active || (state_next != state_reg)) begin
            wdog_next = '0;
        end else begin
            wdog_next = wdog_reg + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_fram_i2c_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fram_i2c_ctrl
//
// Bench for fram_i2c_ctrl with two-byte word addresses and a short watchdog.
// A behavioural I2C master answers commands and bytes (randomly throttled),
// and expected commands, bus bytes, read bytes and completion status are
// queued when a request is set up and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fram_i2c_ctrl;

    localparam int         AB = 2;
    localparam int         MB = 16;
    localparam int         TO = 50;
    localparam logic [2:0] DS = 3'b101;
    localparam int         LW = $clog2(MB + 1);

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [8*AB-1:0] req_addr;
    logic [LW-1:0]   req_len;
    logic [7:0]      wr_tdata;
    logic            wr_tvalid;
    logic            wr_tready;
    logic [7:0]      rd_tdata;
    logic            rd_tvalid;
    logic            rd_tready;
    logic            rd_tlast;
    logic            done;
    logic            err;
    logic [6:0]      cmd_address;
    logic            cmd_start;
    logic            cmd_read;
    logic            cmd_write_multiple;
    logic            cmd_stop;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [7:0]      s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic            i2c_busy;
    logic            i2c_missed_ack;

    fram_i2c_ctrl #(
        .ADDR_BYTES (AB),
        .DEV_SEL    (DS),
        .MAX_BURST  (MB),
        .TIMEOUT    (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_len            (req_len),
        .wr_tdata           (wr_tdata),
        .wr_tvalid          (wr_tvalid),
        .wr_tready          (wr_tready),
        .rd_tdata           (rd_tdata),
        .rd_tvalid          (rd_tvalid),
        .rd_tready          (rd_tready),
        .rd_tlast           (rd_tlast),
        .done               (done),
        .err                (err),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .m_tdata            (m_tdata),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .m_tlast            (m_tlast),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .i2c_busy           (i2c_busy),
        .i2c_missed_ack     (i2c_missed_ack)
    );

    // Scoreboard queues: cmd entries are {start, read, write_multiple, stop},
    // byte entries are {tlast, data}.
    logic [3:0] exp_cmd[$];
    logic [8:0] exp_m[$];
    logic [8:0] exp_rd[$];
    logic       exp_done[$];
    logic [7:0] wr_sup[$];
    logic [7:0] s_sup[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int done_cyc  = 0;
    int txn       = 0;
    int rd_cmds   = 0;
    int hold_cnt  = 0;
    int hold_after = 0;
    int rd_seen   = 0;
    bit in_hold   = 0;
    bit rnd_en    = 1;
    bit cmd_stall = 0;
    bit m_stall   = 0;
    bit ack_pulse = 0;
    bit wr_seen   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "simulation time limit");
    end

    // Behavioural I2C master and payload endpoints, updated just after each edge.
    initial begin
        cmd_ready      = 1'b0;
        m_tready       = 1'b0;
        s_tvalid       = 1'b0;
        s_tdata        = 8'h00;
        rd_tready      = 1'b0;
        wr_tvalid      = 1'b0;
        wr_tdata       = 8'h00;
        i2c_missed_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = !cmd_stall && (!rnd_en || $urandom_range(0, 3) != 0);
            m_tready  = !m_stall && (!rnd_en || $urandom_range(0, 3) != 0);
            wr_tvalid = (wr_sup.size() > 0) && (!rnd_en || $urandom_range(0, 3) != 0);
            wr_tdata  = (wr_sup.size() > 0) ? wr_sup[0] : 8'h00;
            s_tvalid  = (rd_cmds > 0) && (s_sup.size() > 0);
            s_tdata   = s_tvalid ? s_sup[0] : 8'h00;
            in_hold   = (hold_cnt > 0);
            if (hold_cnt > 0) begin
                rd_tready = 1'b0;
                hold_cnt--;
            end else begin
                rd_tready = !rnd_en || $urandom_range(0, 3) != 0;
            end
            i2c_missed_ack = ack_pulse;
            ack_pulse      = 0;
        end
    end

    // Monitor: handshakes are evaluated mid-cycle, ahead of the edge that takes them.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_tready) wr_seen = 1;
            if (in_hold) check("s_tready_hold", s_tready, 0);
            if (cmd_valid && cmd_ready) begin
                check("cmd_avail", exp_cmd.size() > 0, 1);
                check("cmd_addr", cmd_address, {4'b1010, DS});
                if (exp_cmd.size() > 0)
                    check("cmd_bits", {cmd_start, cmd_read, cmd_write_multiple, cmd_stop}, exp_cmd.pop_front());
                if (cmd_read) rd_cmds++;
            end
            if (m_tvalid && m_tready) begin
                check("m_avail", exp_m.size() > 0, 1);
                if (exp_m.size() > 0) check("m_byte", {m_tlast, m_tdata}, exp_m.pop_front());
            end
            if (wr_tvalid && wr_tready && wr_sup.size() > 0) void'(wr_sup.pop_front());
            if (s_tvalid && s_tready) begin
                if (s_sup.size() > 0) void'(s_sup.pop_front());
                if (rd_cmds > 0) rd_cmds--;
            end
            if (rd_tvalid && rd_tready) begin
                check("rd_avail", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) check("rd_byte", {rd_tlast, rd_tdata}, exp_rd.pop_front());
                rd_seen++;
                if (rd_seen == hold_after) hold_cnt = 20;
            end
            if (done) begin
                check("done_avail", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) check("done_err", err, exp_done.pop_front());
                done_cyc = cyc;
                txn++;
                $display("[TB] txn %0d done err=%0b at cycle %0d", txn, err, cyc);
            end
        end
    end

    task automatic push_expect(input bit wr, input logic [15:0] addr, input int len,
                               input logic [7:0] base, input bit err_exp);
        int n;
        logic [7:0] d;
        n = (len == 0) ? 1 : ((len > MB) ? MB : len);
        exp_cmd.push_back(4'b1010);
        exp_m.push_back({1'b0, addr[15:8]});
        exp_m.push_back({!wr, addr[7:0]});
        for (int i = 1; i <= n; i++) begin
            d = base + 8'((i - 1) * 37);
            if (wr) begin
                wr_sup.push_back(d);
                exp_m.push_back({(i == n), d});
            end else begin
                exp_cmd.push_back({(i == 1), 1'b1, 1'b0, (i == n)});
                s_sup.push_back(d);
                exp_rd.push_back({(i == n), d});
            end
        end
        if (wr) exp_cmd.push_back(4'b0001);
        exp_done.push_back(err_exp);
    endtask

    task automatic send_req(input bit wr, input logic [15:0] addr, input int len);
        bit ok;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = LW'(len);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                acc_cyc = cyc;
                break;
            end
        end
        check("req_accept", ok, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (exp_done.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", ok, 1);
        check("cmd_left", exp_cmd.size(), 0);
        check("m_left", exp_m.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        exp_cmd.delete();
        exp_m.delete();
        exp_rd.delete();
        exp_done.delete();
    endtask

    task automatic run_txn(input bit wr, input logic [15:0] addr, input int len, input logic [7:0] base);
        push_expect(wr, addr, len, base, 1'b0);
        send_req(wr, addr, len);
        wait_done();
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        i2c_busy  = 1'b0;

        // Reset state: everything quiet even though the master is idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {req_ready, wr_tready, m_tvalid, m_tlast, cmd_valid, cmd_start,
                           cmd_stop, s_tready, rd_tvalid, rd_tlast, done, err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
        @(posedge clk);
        #1;
        i2c_busy = 1'b1;
        @(negedge clk);
        check("ready_while_busy", req_ready, 0);
        @(posedge clk);
        #1;
        i2c_busy = 1'b0;

        // Single-byte write and three-byte read.
        run_txn(1'b1, 16'h0004, 1, 8'hA5);
        run_txn(1'b0, 16'h1234, 3, 8'h11);
        // Longer write and an over-long read clamped to the burst limit.
        run_txn(1'b1, 16'hBEEF, 5, 8'h40);
        run_txn(1'b0, 16'h0F00, 20, 8'h90);

        // Read consumer stalls for 20 cycles after the second byte.
        rd_seen    = 0;
        hold_after = 2;
        run_txn(1'b0, 16'h2200, 6, 8'h30);
        hold_after = 0;

        // Missed ACK while the address is on the bus.
        m_stall = 1;
        wr_seen = 0;
        exp_cmd.push_back(4'b1010);
        exp_cmd.push_back(4'b0001);
        exp_done.push_back(1'b1);
        wr_sup.push_back(8'h77);
        send_req(1'b1, 16'h0040, 2);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_tvalid) begin
                ok = 1;
                break;
            end
        end
        check("ack_addr_phase", ok, 1);
        ack_pulse = 1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        m_stall = 0;
        wait_done();
        check("ack_no_wr_tready", wr_seen, 0);
        wr_sup.delete();

        // Master never accepts a command: watchdog aborts, then a clean retry.
        cmd_stall = 1;
        exp_done.push_back(1'b1);
        send_req(1'b0, 16'h0100, 1);
        wait_done();
        check("tmo_cycles", done_cyc - acc_cyc, TO + 1);
        cmd_stall = 0;
        run_txn(1'b0, 16'h0100, 2, 8'hC3);

        // Reset while waiting for write payload.
        rnd_en = 0;
        exp_cmd.push_back(4'b1010);
        exp_m.push_back({1'b0, 8'h0A});
        exp_m.push_back({1'b0, 8'hBC});
        send_req(1'b1, 16'h0ABC, 2);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (exp_m.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("reach_wdata", ok, 1);
        @(negedge clk);
        check("wdata_pre", wr_tready, 1);
        #1;
        rst      = 1'b1;
        i2c_busy = 1'b1;
        #1;
        check("rst_wdata_outs", {req_ready, wr_tready, m_tvalid, m_tlast, cmd_valid, cmd_start,
                                 cmd_stop, s_tready, rd_tvalid, rd_tlast, done, err}, 0);
        exp_cmd.delete();
        exp_m.delete();
        exp_rd.delete();
        exp_done.delete();
        wr_sup.delete();
        s_sup.delete();
        rd_cmds = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_rst", req_ready, 0);
        @(posedge clk);
        #1;
        i2c_busy = 1'b0;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        // Zero length moves exactly one byte.
        run_txn(1'b1, 16'h0007, 0, 8'h5A);
        run_txn(1'b0, 16'h0008, 0, 8'h6B);
        rnd_en = 1;

        for (int t = 0; t < 4; t++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(1, MB)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
